// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode, FSM state and opcode class types for the 16-bit RISC core
package risc_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,  OP_STORE = 4'd1,  OP_ADD   = 4'd2,  OP_SUB   = 4'd3,
    OP_AND   = 4'd4,  OP_OR    = 4'd5,  OP_XOR   = 4'd6,  OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,  OP_MOV   = 4'd9,  OP_CMP   = 4'd10, OP_TST   = 4'd11,
    OP_BR    = 4'd12, OP_ILL13 = 4'd13, OP_ILL14 = 4'd14, OP_HALT  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_LOAD      = 3'd0,
    CLS_STORE     = 3'd1,
    CLS_ALU_WB    = 3'd2,
    CLS_ALU_FLAGS = 3'd3,
    CLS_BRANCH    = 3'd4,
    CLS_ILLEGAL   = 3'd5,
    CLS_HALT      = 3'd6
  } op_class_e;

endpackage

// File: rtl/op_class_decode.sv
// rtl/op_class_decode.sv - combinational opcode to instruction class mapping
module op_class_decode
  import risc_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode_e'(opcode))
      OP_LOAD:  op_class = CLS_LOAD;
      OP_STORE: op_class = CLS_STORE;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_MOV:
                op_class = CLS_ALU_WB;
      OP_CMP, OP_TST:
                op_class = CLS_ALU_FLAGS;
      OP_BR:    op_class = CLS_BRANCH;
      OP_HALT:  op_class = CLS_HALT;
      default:  op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the PC
// Optional MEM wait-state timeout is enabled by defining SEQ_TIMEOUT_EN.
module instr_sequencer
  import risc_pkg::*;
#(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            instr_valid,
  input  logic [3:0]      opcode,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            dmem_ready,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            ir_load,
  output logic            alu_en,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            rf_we,
  output logic            wb_sel,
  output logic [2:0]      state,
  output logic            halted,
  output logic            fault,
  output logic [15:0]     instr_count
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  op_class_e       op_class;
  logic            retire;
  logic            timeout_hit;

  op_class_decode u_op_class_decode (
    .opcode   (opcode),
    .op_class (op_class)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (state_q == S_EXEC)
      wait_d = '0;
    else if (state_q == S_MEM && !dmem_ready)
      wait_d = wait_q + 16'd1;
  end

  // Fires on the MEM cycle whose stall would bring the count to the limit.
  assign timeout_hit = (state_q == S_MEM) && !dmem_ready &&
                       (wait_q == 16'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign timeout_hit = (MEM_TIMEOUT < 0);
`endif

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_ILLEGAL: state_d = S_FAULT;
          CLS_HALT:    state_d = S_HALT;
          default:     state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (op_class)
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          CLS_ALU_WB:          state_d = S_WB;
          default:             retire  = 1'b1;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (op_class == CLS_STORE) retire  = 1'b1;
          else                       state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB:     retire = 1'b1;
      default:  state_d = state_q;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    if (retire) begin
      // Branch retires in EXEC, the only cycle branch inputs are looked at.
      if (state_q == S_EXEC && op_class == CLS_BRANCH && branch_taken)
        pc_d = branch_target;
      else
        pc_d = pc_q + PC_W'(1);
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign state       = state_q;
  assign imem_req    = (state_q == S_FETCH);
  assign ir_load     = (state_q == S_FETCH) && instr_valid;
  assign alu_en      = (state_q == S_EXEC);
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) && (op_class == CLS_STORE);
  assign rf_we       = (state_q == S_WB);
  assign wb_sel      = (state_q == S_WB) && (op_class == CLS_LOAD);
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed table-driven bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, run, instr_valid, branch_taken, dmem_ready;
  logic [3:0]  opcode;
  logic [15:0] branch_target;
  logic [15:0] pc, instr_count;
  logic        imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, wb_sel, halted, fault;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_sequencer #(
    .PC_W        (16),
    .RESET_PC    (16'h0000),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .dmem_ready    (dmem_ready),
    .pc            (pc),
    .imem_req      (imem_req),
    .ir_load       (ir_load),
    .alu_en        (alu_en),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .rf_we         (rf_we),
    .wb_sel        (wb_sel),
    .state         (state),
    .halted        (halted),
    .fault         (fault),
    .instr_count   (instr_count)
  );

  // strb = {imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, wb_sel}; hf = {halted, fault}
  typedef struct {
    logic        rst_n, run, iv;
    logic [3:0]  op;
    logic        bt;
    logic [15:0] tgt;
    logic        dr;
    logic [2:0]  st;
    logic [15:0] pc;
    logic [6:0]  strb;
    logic [1:0]  hf;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic rn, input logic iv, input logic [3:0] op,
                     input logic bt, input logic [15:0] tgt, input logic dr,
                     input logic [2:0] st, input logic [15:0] epc, input logic [6:0] strb,
                     input logic [1:0] hf, input logic [15:0] cnt);
    vec_t v;
    v.rst_n = r; v.run = rn; v.iv = iv; v.op = op; v.bt = bt; v.tgt = tgt; v.dr = dr;
    v.st = st; v.pc = epc; v.strb = strb; v.hf = hf; v.cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input int iv_w, input int dr_w,
                           input int exp_cyc, input string nm);
    int cyc, ivc, drc;
    logic [15:0] c0;
    c0 = instr_count; cyc = 0; ivc = 0; drc = 0;
    rst_n = 1'b1; run = 1'b1; opcode = op; branch_taken = 1'b0;
    while (state != 3'd1 && cyc < 5) begin
      @(posedge clk); #4; cyc++;
    end
    cyc = 0;
    while (instr_count == c0 && cyc < 60) begin
      instr_valid = (ivc >= iv_w);
      dmem_ready  = (drc >= dr_w);
      if (state == 3'd1) ivc++;
      if (state == 3'd4) drc++;
      cyc++;
      @(posedge clk); #4;
    end
    chk(nm, cyc, exp_cyc);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; opcode = 4'd0;
    branch_taken = 1'b0; branch_target = 16'h0; dmem_ready = 1'b0;

    // ALU op 2, zero waits
    add(1,0,0, 2,0,16'h0,0, 0,16'h0,7'b0000000,2'b00,0);
    add(1,1,0, 2,0,16'h0,0, 0,16'h0,7'b0000000,2'b00,0);
    add(1,1,1, 2,0,16'h0,0, 1,16'h0,7'b1100000,2'b00,0);
    add(1,1,1, 2,0,16'h0,0, 2,16'h0,7'b0000000,2'b00,0);
    add(1,1,1, 2,0,16'h0,0, 3,16'h0,7'b0010000,2'b00,0);
    add(1,1,1, 2,0,16'h0,0, 5,16'h0,7'b0000010,2'b00,0);
    // LOAD with one fetch wait and three MEM waits
    add(1,1,0, 0,0,16'h0,0, 1,16'h1,7'b1000000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 1,16'h1,7'b1100000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 2,16'h1,7'b0000000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 3,16'h1,7'b0010000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 4,16'h1,7'b0001000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 4,16'h1,7'b0001000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 4,16'h1,7'b0001000,2'b00,1);
    add(1,1,1, 0,0,16'h0,1, 4,16'h1,7'b0001000,2'b00,1);
    add(1,1,1, 0,0,16'h0,0, 5,16'h1,7'b0000011,2'b00,1);
    // STORE with run dropped mid-instruction, retires to IDLE
    add(1,0,1, 1,0,16'h0,0, 1,16'h2,7'b1100000,2'b00,2);
    add(1,0,1, 1,0,16'h0,0, 2,16'h2,7'b0000000,2'b00,2);
    add(1,0,1, 1,0,16'h0,0, 3,16'h2,7'b0010000,2'b00,2);
    add(1,0,1, 1,0,16'h0,1, 4,16'h2,7'b0001100,2'b00,2);
    add(1,0,1, 1,0,16'h0,1, 0,16'h3,7'b0000000,2'b00,3);
    // BRANCH taken, then not taken; branch inputs outside EXEC are noise
    add(1,1,1,12,0,16'h0000,0, 0,16'h3,7'b0000000,2'b00,3);
    add(1,1,1,12,1,16'h0077,0, 1,16'h3,7'b1100000,2'b00,3);
    add(1,1,1,12,1,16'h0077,0, 2,16'h3,7'b0000000,2'b00,3);
    add(1,1,1,12,1,16'h0040,0, 3,16'h3,7'b0010000,2'b00,3);
    add(1,1,1,12,0,16'h0099,0, 1,16'h40,7'b1100000,2'b00,4);
    add(1,1,1,12,1,16'h0055,0, 2,16'h40,7'b0000000,2'b00,4);
    add(1,1,1,12,0,16'h0055,0, 3,16'h40,7'b0010000,2'b00,4);
    // ALU flags-only
    add(1,1,1,10,0,16'h0,0, 1,16'h41,7'b1100000,2'b00,5);
    add(1,1,1,10,0,16'h0,0, 2,16'h41,7'b0000000,2'b00,5);
    add(1,1,1,10,0,16'h0,0, 3,16'h41,7'b0010000,2'b00,5);
    // illegal opcode 13 faults; only reset leaves
    add(1,1,1,13,0,16'h0,0, 1,16'h42,7'b1100000,2'b00,6);
    add(1,1,1,13,0,16'h0,0, 2,16'h42,7'b0000000,2'b00,6);
    add(1,1,1,13,0,16'h0,1, 7,16'h42,7'b0000000,2'b01,6);
    add(1,1,1,13,0,16'h0,1, 7,16'h42,7'b0000000,2'b01,6);
    add(0,1,1,13,0,16'h0,1, 7,16'h42,7'b0000000,2'b01,6);
    // HALT
    add(1,1,1,15,0,16'h0,0, 0,16'h0,7'b0000000,2'b00,0);
    add(1,1,1,15,0,16'h0,0, 1,16'h0,7'b1100000,2'b00,0);
    add(1,1,1,15,0,16'h0,0, 2,16'h0,7'b0000000,2'b00,0);
    add(1,1,1,15,0,16'h0,0, 6,16'h0,7'b0000000,2'b10,0);
    add(1,1,1,15,0,16'h0,0, 6,16'h0,7'b0000000,2'b10,0);
    add(0,1,1,15,0,16'h0,0, 6,16'h0,7'b0000000,2'b10,0);
    // reset during MEM of a STORE
    add(1,1,1, 1,0,16'h0,0, 0,16'h0,7'b0000000,2'b00,0);
    add(1,1,1, 1,0,16'h0,0, 1,16'h0,7'b1100000,2'b00,0);
    add(1,1,1, 1,0,16'h0,0, 2,16'h0,7'b0000000,2'b00,0);
    add(1,1,1, 1,0,16'h0,0, 3,16'h0,7'b0010000,2'b00,0);
    add(1,1,1, 1,0,16'h0,0, 4,16'h0,7'b0001100,2'b00,0);
    add(0,1,1, 1,0,16'h0,0, 4,16'h0,7'b0001100,2'b00,0);
    add(1,0,1, 1,0,16'h0,0, 0,16'h0,7'b0000000,2'b00,0);
    // branch to 0xFFFF, then an ALU op wraps pc to 0
    add(1,1,1,12,0,16'h0000,0, 0,16'h0,7'b0000000,2'b00,0);
    add(1,1,1,12,0,16'h0000,0, 1,16'h0,7'b1100000,2'b00,0);
    add(1,1,1,12,0,16'h0000,0, 2,16'h0,7'b0000000,2'b00,0);
    add(1,1,1,12,1,16'hFFFF,0, 3,16'h0,7'b0010000,2'b00,0);
    add(1,1,1, 2,0,16'h0000,0, 1,16'hFFFF,7'b1100000,2'b00,1);
    add(1,1,1, 2,0,16'h0000,0, 2,16'hFFFF,7'b0000000,2'b00,1);
    add(1,1,1, 2,0,16'h0000,0, 3,16'hFFFF,7'b0010000,2'b00,1);
    add(1,0,1, 2,0,16'h0000,0, 5,16'hFFFF,7'b0000010,2'b00,1);
    add(1,0,1, 2,0,16'h0000,0, 0,16'h0000,7'b0000000,2'b00,2);

    repeat (2) @(posedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #2;
      rst_n = tv[i].rst_n; run = tv[i].run; instr_valid = tv[i].iv; opcode = tv[i].op;
      branch_taken = tv[i].bt; branch_target = tv[i].tgt; dmem_ready = tv[i].dr;
      #2;
      chk($sformatf("row%0d_state", i), state, tv[i].st);
      chk($sformatf("row%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("row%0d_strobes", i),
          {imem_req, ir_load, alu_en, dmem_req, dmem_we, rf_we, wb_sel}, tv[i].strb);
      chk($sformatf("row%0d_halt_fault", i), {halted, fault}, tv[i].hf);
      chk($sformatf("row%0d_count", i), instr_count, tv[i].cnt);
    end

    run_instr(4'd5,  0, 0, 4,  "cycles_alu_wb");
    run_instr(4'd0,  0, 0, 5,  "cycles_load");
    run_instr(4'd1,  0, 0, 4,  "cycles_store");
    run_instr(4'd11, 0, 0, 3,  "cycles_alu_flags");
    run_instr(4'd12, 0, 0, 3,  "cycles_branch");
    run_instr(4'd0,  2, 3, 10, "cycles_load_waits");
    run_instr(4'd1,  0, 2, 6,  "cycles_store_waits");
    chk("pc_after_cycle_runs", pc, 16'h0007);

`ifdef SEQ_TIMEOUT_EN
    run_instr(4'd1, 0, 3, 7, "timeout_ready_on_limit");
    begin
      int cyc, mem_cyc;
      logic [15:0] pc0;
      pc0 = pc; cyc = 0; mem_cyc = 0;
      opcode = 4'd1; instr_valid = 1'b1; dmem_ready = 1'b0;
      while (state != 3'd7 && cyc < 40) begin
        if (state == 3'd4) mem_cyc++;
        cyc++;
        @(posedge clk); #4;
      end
      chk("timeout_mem_cycles", mem_cyc, 4);
      chk("timeout_fault", fault, 1'b1);
      chk("timeout_dmem_req", dmem_req, 1'b0);
      chk("timeout_pc_frozen", pc, pc0);
    end
`else
    run_instr(4'd1, 0, 20, 24, "long_mem_wait");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
